// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter sequencer with IDLE/RUN/HALT control and branch-target LUT
// Branch targets come from a register LUT; a same-edge LUT write is seen only by later branches.
module pc_fetch #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 32,
  localparam int LI       = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
  input  logic            Clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [PC_W-1:0] Start_addr,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            branch,
  input  logic [LI-1:0]   branch_idx,
  input  logic            lut_we,
  input  logic [LI-1:0]   lut_addr,
  input  logic [PC_W-1:0] lut_data,
  output logic [PC_W-1:0] Prog_ctr,
  output logic            running,
  output logic            done,
  output logic [15:0]     Instr_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [PC_W-1:0] lut_q [LUT_DEPTH];
  logic [PC_W-1:0] target;
  logic [31:0]     bidx_ext, widx_ext;

  assign bidx_ext = 32'(branch_idx);
  assign widx_ext = 32'(lut_addr);

  // Out-of-range indices read as zero and are never written.
  assign target = (bidx_ext < 32'(LUT_DEPTH)) ? lut_q[branch_idx] : '0;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
    end else if (lut_we && (widx_ext < 32'(LUT_DEPTH))) begin
      lut_q[lut_addr] <= lut_data;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = Start_addr;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (halt_req)    state_d = HALT;
          else if (branch) pc_d    = target;
          else             pc_d    = pc_q + PC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Prog_ctr  = pc_q;
  assign Instr_cnt = cnt_q;
  assign running   = (state_q == RUN);
  assign done      = (state_q == HALT);

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed scoreboard bench for pc_fetch
module tb_pc_fetch;

  logic       Clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [9:0] Start_addr;
  logic       stall, halt_req, branch;
  logic [4:0] branch_idx;
  logic       lut_we;
  logic [4:0] lut_addr;
  logic [9:0] lut_data;
  logic [9:0] Prog_ctr;
  logic       running, done;
  logic [15:0] Instr_cnt;

  typedef struct {
    string       tag;
    logic [9:0]  pc;
    logic        run;
    logic        dn;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   nvec  = 0;
  int   fails = 0;

  pc_fetch dut (
    .Clk        (Clk),
    .reset_n    (reset_n),
    .start      (start),
    .Start_addr (Start_addr),
    .stall      (stall),
    .halt_req   (halt_req),
    .branch     (branch),
    .branch_idx (branch_idx),
    .lut_we     (lut_we),
    .lut_addr   (lut_addr),
    .lut_data   (lut_data),
    .Prog_ctr   (Prog_ctr),
    .running    (running),
    .done       (done),
    .Instr_cnt  (Instr_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] expv);
    nvec++;
    assert (act === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, expv);
    end
  endtask

  task automatic expect_push(input string tag, input logic [9:0] pc, input logic run,
                             input logic dn, input logic [15:0] cnt);
    exp_t e;
    e.tag = tag; e.pc = pc; e.run = run; e.dn = dn; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      nvec++;
      fails++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".pc"},   16'(Prog_ctr), 16'(e.pc));
      chk({e.tag, ".run"},  16'(running),  16'(e.run));
      chk({e.tag, ".done"}, 16'(done),     16'(e.dn));
      chk({e.tag, ".cnt"},  Instr_cnt,     e.cnt);
    end
  endtask

  task automatic drive(input logic st, input logic [9:0] sa, input logic sl, input logic hr,
                       input logic br, input logic [4:0] bi, input logic we,
                       input logic [4:0] wa, input logic [9:0] wd);
    @(negedge Clk);
    start = st; Start_addr = sa; stall = sl; halt_req = hr;
    branch = br; branch_idx = bi; lut_we = we; lut_addr = wa; lut_data = wd;
  endtask

  task automatic step(input string tag, input logic st, input logic [9:0] sa, input logic sl,
                      input logic hr, input logic br, input logic [4:0] bi, input logic we,
                      input logic [4:0] wa, input logic [9:0] wd,
                      input logic [9:0] e_pc, input logic e_run, input logic e_dn,
                      input logic [15:0] e_cnt);
    drive(st, sa, sl, hr, br, bi, we, wa, wd);
    expect_push(tag, e_pc, e_run, e_dn, e_cnt);
    @(posedge Clk);
    #1;
    check_pop();
  endtask

  initial begin
    reset_n = 1'b0;
    start = 0; Start_addr = '0; stall = 0; halt_req = 0; branch = 0;
    branch_idx = '0; lut_we = 0; lut_addr = '0; lut_data = '0;
    #1;
    expect_push("reset", 10'd0, 1'b0, 1'b0, 16'd0);
    check_pop();

    @(negedge Clk);
    reset_n = 1'b1;

    //                    st sa    sl hr br bi  we wa  wd      pc  run dn cnt
    step("idle_lutwr",    0, 0,    0, 0, 0, 0,  1, 3,  200,    0,  0, 0, 0);
    step("start5",        1, 5,    0, 0, 0, 0,  0, 0,  0,      5,  1, 0, 0);
    step("inc1",          0, 0,    0, 0, 0, 0,  0, 0,  0,      6,  1, 0, 1);
    step("inc2",          0, 0,    0, 0, 0, 0,  0, 0,  0,      7,  1, 0, 2);
    step("inc3",          0, 0,    0, 0, 0, 0,  0, 0,  0,      8,  1, 0, 3);
    step("inc4",          0, 0,    0, 0, 0, 0,  0, 0,  0,      9,  1, 0, 4);
    step("inc5",          0, 0,    0, 0, 0, 0,  0, 0,  0,      10, 1, 0, 5);
    step("branch3",       0, 0,    0, 0, 1, 3,  0, 0,  0,      200,1, 0, 6);
    step("br_same_wr",    0, 0,    0, 0, 1, 3,  1, 3,  300,    200,1, 0, 7);
    step("br_after_wr",   0, 0,    0, 0, 1, 3,  0, 0,  0,      300,1, 0, 8);
    step("inc_wr7",       0, 0,    0, 0, 0, 0,  1, 7,  1023,   301,1, 0, 9);
    step("br_to_1023",    0, 0,    0, 0, 1, 7,  0, 0,  0,      1023,1,0, 10);
    step("wrap",          0, 0,    0, 0, 0, 0,  0, 0,  0,      0,  1, 0, 11);
    step("br_unwritten",  0, 0,    0, 0, 1, 20, 0, 0,  0,      0,  1, 0, 12);
    step("start_ignored", 1, 77,   0, 0, 0, 0,  0, 0,  0,      1,  1, 0, 13);
    step("stall_halt1",   0, 0,    1, 1, 0, 0,  0, 0,  0,      1,  1, 0, 13);
    step("stall_halt2",   0, 0,    1, 1, 1, 3,  0, 0,  0,      1,  1, 0, 13);
    step("halt",          0, 0,    0, 1, 0, 0,  0, 0,  0,      1,  0, 1, 14);
    step("halt_ign_br",   0, 0,    0, 1, 1, 3,  0, 0,  0,      1,  0, 1, 14);
    step("start0_stall",  1, 0,    1, 0, 0, 0,  0, 0,  0,      0,  1, 0, 0);
    step("run_a",         0, 0,    0, 0, 0, 0,  0, 0,  0,      1,  1, 0, 1);
    step("run_b",         0, 0,    0, 0, 0, 0,  0, 0,  0,      2,  1, 0, 2);

    #2;
    reset_n = 1'b0;
    #1;
    expect_push("async_rst", 10'd0, 1'b0, 1'b0, 16'd0);
    check_pop();
    step("rst_ign_start", 1, 9,    0, 0, 0, 0,  1, 3,  55,     0,  0, 0, 0);
    reset_n = 1'b1;
    step("post_rst_idle", 0, 0,    0, 0, 0, 0,  0, 0,  0,      0,  0, 0, 0);
    step("start50",       1, 50,   0, 0, 0, 0,  0, 0,  0,      50, 1, 0, 0);
    step("lut_cleared",   0, 0,    0, 0, 1, 3,  0, 0,  0,      0,  1, 0, 1);
    step("run_c",         0, 0,    0, 0, 0, 0,  0, 0,  0,      1,  1, 0, 2);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (65533) @(posedge Clk);
    #1;
    expect_push("sat_reach", 10'd1022, 1'b1, 1'b0, 16'hFFFF);
    check_pop();
    step("sat_hold",      0, 0,    0, 0, 0, 0,  0, 0,  0,      1023,1,0, 16'hFFFF);
    step("sat_wrap",      0, 0,    0, 0, 0, 0,  0, 0,  0,      0,  1, 0, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter PC_W, default 10, program counter width in bits.
REQ-002 Parameter LUT_DEPTH, default 32, number of branch-target entries; index width LI = clog2(LUT_DEPTH).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  begin execution at Start_addr.
REQ-007 Start_addr  input  PC_W  first instruction address.
REQ-008 stall  input  1  freeze PC, state and counter this cycle.
REQ-009 halt_req  input  1  decoder has fetched a halt instruction.
REQ-010 branch  input  1  taken-branch indication from the ALU.
REQ-011 branch_idx  input  LI  branch-target LUT index from the current instruction.
REQ-012 lut_we  input  1  LUT write enable.
REQ-013 lut_addr  input  LI  LUT write index.
REQ-014 lut_data  input  PC_W  LUT write data.
REQ-015 Prog_ctr  output  PC_W  current instruction address, registered.
REQ-016 running  output  1  high in state RUN.
REQ-017 done  output  1  high in state HALT.
REQ-018 Instr_cnt  output  16  instructions retired since the last start.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, RUN and HALT. running is high only in RUN and done is high only in HALT; both SHALL be decoded directly from registered state.
REQ-020 In IDLE or HALT, start=1 SHALL on the next edge set Prog_ctr=Start_addr, Instr_cnt=0 and state=RUN. stall SHALL have no effect on this transition.
REQ-021 In IDLE or HALT with start=0, Prog_ctr and Instr_cnt SHALL hold.
REQ-022 In RUN, start SHALL be ignored.
REQ-023 In RUN, each edge SHALL apply the first matching rule in this priority order:
- stall=1: hold everything.
- halt_req=1: enter HALT; Prog_ctr holds.
- branch=1: Prog_ctr = LUT[branch_idx].
- otherwise: Prog_ctr = Prog_ctr + 1.
REQ-024 Increment SHALL wrap modulo 2^PC_W, so all-ones + 1 = 0.
REQ-025 Instr_cnt SHALL increment on every non-stalled RUN edge, including the halt edge, and saturate at 16'hFFFF.
REQ-026 The LUT SHALL be LUT_DEPTH x PC_W registers, writable in any state.
REQ-027 A LUT write lands on the edge.
REQ-028 A branch reading the same index on the same edge SHALL use the pre-write value.
REQ-029 A branch_idx of LUT_DEPTH or greater SHALL yield a target of 0.
REQ-030 branch and halt_req SHALL be ignored outside RUN.
REQ-031 Latency: a control input sampled on edge N SHALL be reflected in Prog_ctr and the status outputs after edge N, with no combinational path from any input to any output.

Reset
REQ-032 reset_n=0 SHALL immediately, without waiting for a clock edge, force the following:
- state = IDLE;
- Prog_ctr = 0, Instr_cnt = 0;
- running = 0, done = 0;
- all LUT entries = 0.
REQ-033 Reset asserted mid-RUN SHALL abort execution. After deassertion the block SHALL remain in IDLE until start.
REQ-034 Inputs SHALL be ignored on the edge on which reset_n is low.

Verification
REQ-035 Reset, then start=1 with Start_addr=5, then 4 idle-input cycles -> Prog_ctr 5,6,7,8,9; running=1; Instr_cnt=4.
REQ-036 Write LUT[3]=200; in RUN at PC=10 apply branch=1 with branch_idx=3 -> next Prog_ctr=200. The same case with lut_we to LUT[3]=300 on the same edge -> still 200, and a later branch to index 3 -> 300.
REQ-037 In RUN at PC=1023 (PC_W=10) with no branch -> Prog_ctr=0.
REQ-038 Apply stall=1 together with halt_req=1 for 2 cycles, then halt_req=1 alone:
- during the stall, PC and Instr_cnt hold and running=1;
- then done=1, running=0 and PC is held;
- then start with Start_addr=0 -> RUN, Instr_cnt=0.
REQ-039 Assert reset_n=0 asynchronously mid-RUN (between edges) -> outputs go to 0 and state to IDLE before the next edge; after release, no PC change until start.
